// File: rtl/conv_tx_framer.sv
// Rate-1/2 K=3 convolutional encoder framer: bit FIFO, IDLE/DATA/TAIL frame FSM, registered symbol output.
// Optional macro CONV_TX_ERRINJ_EN adds err_inj_i, XORed into d_out while valid_o is high.
module conv_tx_framer #(
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
`ifdef CONV_TX_ERRINJ_EN
    input  logic [1:0] err_inj_i,
`endif
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       sof_o,
    output logic       eof_o,
    output logic       busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    logic              fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              full, empty, push, pop, head;

    state_t            state_reg, state_next;
    logic [1:0]        enc_reg, enc_next, enc_cur;
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic              tail_reg, tail_next;
    logic [1:0]        d_out_reg, d_out_next;
    logic              valid_reg, valid_next;
    logic              sof_reg, sof_next;
    logic              eof_reg, eof_next;
    logic              emit, b;

    assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign push  = enable_i && !full;
    assign head  = fifo_mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= d_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            enc_reg     <= 2'b00;
            bit_cnt_reg <= '0;
            tail_reg    <= 1'b0;
            d_out_reg   <= 2'b00;
            valid_reg   <= 1'b0;
            sof_reg     <= 1'b0;
            eof_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            enc_reg     <= enc_next;
            bit_cnt_reg <= bit_cnt_next;
            tail_reg    <= tail_next;
            d_out_reg   <= d_out_next;
            valid_reg   <= valid_next;
            sof_reg     <= sof_next;
            eof_reg     <= eof_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        enc_next     = enc_reg;
        enc_cur      = enc_reg;
        bit_cnt_next = bit_cnt_reg;
        tail_next    = tail_reg;
        d_out_next   = d_out_reg;
        valid_next   = 1'b0;
        sof_next     = 1'b0;
        eof_next     = 1'b0;
        pop          = 1'b0;
        emit         = 1'b0;
        b            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    emit         = 1'b1;
                    b            = head;
                    enc_cur      = 2'b00;
                    sof_next     = 1'b1;
                    bit_cnt_next = CW'(1);
                    state_next   = DATA;
                end
            end
            DATA: begin
                // An empty FIFO simply stalls the frame; encoder state and count hold.
                if (!empty) begin
                    pop          = 1'b1;
                    emit         = 1'b1;
                    b            = head;
                    bit_cnt_next = bit_cnt_reg + CW'(1);
                    if (bit_cnt_reg == CW'(FRAME_LEN - 1)) begin
                        state_next = TAIL;
                        tail_next  = 1'b0;
                    end
                end
            end
            TAIL: begin
                emit = 1'b1;
                if (tail_reg) begin
                    eof_next     = 1'b1;
                    tail_next    = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    tail_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (emit) begin
            d_out_next = {b ^ enc_cur[1] ^ enc_cur[0], b ^ enc_cur[0]};
            enc_next   = {b, enc_cur[1]};
            valid_next = 1'b1;
        end
    end

    assign ready_o = !full;
    assign valid_o = valid_reg;
    assign sof_o   = sof_reg;
    assign eof_o   = eof_reg;
    assign busy_o  = (state_reg != IDLE);
`ifdef CONV_TX_ERRINJ_EN
    assign d_out   = d_out_reg ^ (valid_reg ? err_inj_i : 2'b00);
`else
    assign d_out   = d_out_reg;
`endif

endmodule

// File: tb/tb_conv_tx_framer.sv
// Randomized bench for conv_tx_framer against a queue-based frame/encoder reference model.
module tb_conv_tx_framer;

    localparam int FL = 4;
    localparam int FD = 8;

    logic       clk;
    logic       rst;
    logic       enable_i;
    logic       d_in;
    logic       ready_o, valid_o, sof_o, eof_o, busy_o;
    logic [1:0] d_out;
`ifdef CONV_TX_ERRINJ_EN
    logic [1:0] err_inj;
    initial err_inj = 2'b00;
`endif

    conv_tx_framer #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable_i),
        .d_in     (d_in),
`ifdef CONV_TX_ERRINJ_EN
        .err_inj_i(err_inj),
`endif
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .d_out    (d_out),
        .sof_o    (sof_o),
        .eof_o    (eof_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: pending-bit queue, frame progress and encoder shift state.
    bit         m_fifo[$];
    int         m_nbits = 0;
    int         m_tail  = 0;
    bit         m_s1 = 0, m_s0 = 0;
    bit         e_valid, e_sof, e_eof;
    bit  [1:0]  e_d;

    logic [3:0] log_sym[$];
    int         log_cyc[$];
    int         cyc = 0;
    int         not_ready_seen = 0;

    function automatic void encode(input bit bb);
        e_d     = {bb ^ m_s1 ^ m_s0, bb ^ m_s0};
        m_s0    = m_s1;
        m_s1    = bb;
        e_valid = 1'b1;
    endfunction

    function automatic void model_edge(input bit en, input bit din);
        int pre;
        bit bb;
        pre     = m_fifo.size();
        e_valid = 0; e_sof = 0; e_eof = 0;
        if (m_tail > 0) begin
            e_eof = (m_tail == 1);
            encode(1'b0);
            m_tail--;
            if (m_tail == 0) m_nbits = 0;
        end else if (pre > 0) begin
            bb = m_fifo.pop_front();
            if (m_nbits == 0) begin
                m_s1 = 0; m_s0 = 0; e_sof = 1;
            end
            encode(bb);
            m_nbits++;
            if (m_nbits == FL) m_tail = 2;
        end
        if (en && pre < FD) m_fifo.push_back(din);
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_nbits = 0; m_tail = 0; m_s1 = 0; m_s0 = 0;
    endfunction

    task automatic step(input logic en, input logic din);
        enable_i = en;
        d_in     = din;
        @(posedge clk);
        model_edge(en, din);
        #1;
        check_eq("valid", valid_o, e_valid);
        check_eq("ready", ready_o, (m_fifo.size() < FD));
        check_eq("busy", busy_o, (m_nbits != 0));
        if (e_valid) begin
            check_eq("d_out", d_out, e_d);
            check_eq("sof", sof_o, e_sof);
            check_eq("eof", eof_o, e_eof);
        end
        if (valid_o === 1'b1) begin
            log_sym.push_back({sof_o, eof_o, d_out});
            log_cyc.push_back(cyc);
        end
        if (ready_o === 1'b0) not_ready_seen++;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, ready_o, 1'b1);
        check_eq({tag, "_valid"}, valid_o, 1'b0);
        check_eq({tag, "_dout"}, d_out, 2'b00);
        check_eq({tag, "_sof"}, sof_o, 1'b0);
        check_eq({tag, "_eof"}, eof_o, 1'b0);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
    endtask

    // Called just after a step, i.e. 1 time unit past a rising edge.
    task automatic do_reset(input string tag);
        enable_i = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_outputs({tag, "_held"});
        rst = 1'b1;
    endtask

    // 1,0,1,1 frame with FRAME_LEN=4: 11,10,00,01,01,11, sof first, eof last.
    task automatic check_frame_1011(input string tag, input int span);
        logic [3:0] exp_syms [6];
        exp_syms = '{4'b1011, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0111};
        check_eq({tag, "_count"}, log_sym.size(), 6);
        if (log_sym.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check_eq($sformatf("%s_sym%0d", tag, i), log_sym[i], exp_syms[i]);
            check_eq({tag, "_span"}, log_cyc[5] - log_cyc[0], span);
        end
    endtask

    task automatic clear_log();
        log_sym.delete();
        log_cyc.delete();
    endtask

    initial begin
        int eof_idx;
        rst      = 1'b0;
        enable_i = 1'b0;
        d_in     = 1'b0;
        #12 check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b1;

        clear_log();
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);
        repeat (6) step(0, 0);
        check_frame_1011("seq", 5);

        clear_log();
        step(1, 1); step(1, 0); step(0, 0); step(1, 1); step(1, 1);
        repeat (6) step(0, 0);
        check_frame_1011("gap", 6);

        not_ready_seen = 0;
        repeat (60) step(1, 1'($urandom_range(0, 1)));
        check_eq("full_seen", (not_ready_seen > 0), 1'b1);
        repeat (24) step(0, 0);
        check_eq("drained_busy", busy_o, 1'b0);

        clear_log();
        step(1, 1); step(1, 0); step(1, 1);
        check_eq("pre_reset_syms", log_sym.size(), 2);
        do_reset("midrst");
        clear_log();
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);
        repeat (6) step(0, 0);
        check_frame_1011("postrst", 5);

        clear_log();
        repeat (8) step(1, 1'($urandom_range(0, 1)));
        repeat (16) step(0, 0);
        eof_idx = -1;
        for (int i = 0; i < log_sym.size(); i++)
            if (eof_idx < 0 && log_sym[i][2]) eof_idx = i;
        check_eq("b2b_eof_found", (eof_idx >= 0 && eof_idx + 1 < log_sym.size()), 1'b1);
        if (eof_idx >= 0 && eof_idx + 1 < log_sym.size()) begin
            check_eq("b2b_next_sof", log_sym[eof_idx+1][3], 1'b1);
            check_eq("b2b_gap", log_cyc[eof_idx+1] - log_cyc[eof_idx], 1);
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0)
                do_reset("rndrst");
            else
                step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_tx_framer.md
CONV_TX_FRAMER -- requirements
Module: conv_tx_framer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64, giving data bits per frame (legal range 2..1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving input FIFO entries (power of 2, minimum 2).
REQ-003 SHALL have port clk  input  1  as its single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  as its asynchronous, active-low reset.
REQ-005 SHALL have port enable_i  input  1  qualifying d_in as a valid source bit.
REQ-006 SHALL have port d_in  input  1  carrying the source data bit.
REQ-007 SHALL have port ready_o  output  1  that is high when the FIFO can accept a bit (not full).
REQ-008 SHALL have port valid_o  output  1  that is high when d_out holds a coded symbol.
REQ-009 SHALL have port d_out  output  2  carrying the coded symbol {g0=111, g1=101}.
REQ-010 SHALL have port sof_o  output  1  that is high with the first symbol of a frame.
REQ-011 SHALL have port eof_o  output  1  that is high with the last tail symbol of a frame.
REQ-012 SHALL have port busy_o  output  1  that is high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL accept a bit into the FIFO only when enable_i && ready_o; a bit with enable_i && !ready_o SHALL be dropped.
REQ-014 SHALL keep ready_o low when full, even if a pop occurs in the same cycle; simultaneous push+pop when not full SHALL leave the count unchanged.
REQ-015 SHALL implement a rate-1/2, K=3 encoder with state {s1,s0} (s1 = most recent bit): d_out[1]=b^s1^s0, d_out[0]=b^s0; the state then shifts to {b,s1}.
REQ-016 SHALL implement an FSM with states IDLE, DATA and TAIL.
REQ-017 In IDLE with FIFO non-empty, the FSM SHALL pop a bit, clear {s1,s0} to 00 before encoding it, assert sof_o with its symbol, and enter DATA.
REQ-018 In DATA the FSM SHALL pop one bit per cycle when the FIFO is non-empty; when empty, valid_o SHALL deassert and the frame SHALL stall without losing state.
REQ-019 After FRAME_LEN data bits have been encoded, the FSM SHALL enter TAIL and emit exactly 2 symbols with b=0, one per cycle, without stalling.
REQ-020 SHALL assert eof_o with the second tail symbol and return to IDLE; a new frame MAY start the following cycle.
REQ-021 SHALL register d_out, valid_o, sof_o and eof_o; the symbol SHALL appear the cycle after its pop.
REQ-022 Latency from an accepted write into an empty FIFO in IDLE to valid_o SHALL be 2 cycles.
REQ-023 The data-bit counter SHALL have width clog2(FRAME_LEN+1) and SHALL not wrap within a frame.
REQ-024 sof_o and eof_o SHALL never be high in the same cycle, and each SHALL be high only when valid_o is high.

Reset
REQ-025 While rst is low: FIFO empty, ready_o=1, valid_o=0, d_out=00, sof_o=0, eof_o=0, busy_o=0, FSM=IDLE, {s1,s0}=00, counter=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no eof_o; after release, the next bit starts a fresh frame.

Configuration
REQ-027 With macro CONV_TX_ERRINJ_EN defined, the block SHALL add input port err_inj_i[1:0] and XOR it into d_out on cycles where valid_o=1 (channel-error test mode).
REQ-028 Without CONV_TX_ERRINJ_EN, the err_inj_i port SHALL be absent and d_out SHALL be the uncorrupted code symbol.

Verification
REQ-029 FRAME_LEN=4, bits 1,0,1,1 written on consecutive cycles -> d_out 11,10,00,01,01,11 on 6 consecutive valid cycles; sof_o on the 1st, eof_o on the 6th.
REQ-030 FRAME_LEN=4, one gap cycle between bits 2 and 3 -> the same 6 symbols with exactly one valid_o=0 bubble after the 2nd; busy_o stays high throughout.
REQ-031 FIFO_DEPTH=8, hold enable_i high for 12 cycles with output stalled by full -> ready_o low after 8 accepts; extra bits dropped; count never exceeds 8.
REQ-032 Reset pulse after the 2nd symbol of a frame -> all outputs at reset values; the next frame begins with sof_o and encoder state 00.
REQ-033 CONV_TX_ERRINJ_EN defined, err_inj_i=2'b10 during the 1st symbol of REQ-029 -> d_out=01 for that symbol; the remaining symbols are unchanged.
REQ-034 Back-to-back frames, FRAME_LEN=2, 4 bits preloaded -> eof_o of frame 1 is followed on the next cycle by sof_o of frame 2.
